// File: rtl/teclado_senha_if.sv
// teclado_senha_if: button/lock-side signal bundle for the keypad front end.
//   master  : drives bit_in, bit_stb, limpar, resp_ok, resp_erro;
//             observes senha_out, senha_valida, aberto, bloqueado, tentativas, nbits
//   slave   : the keypad controller side (mirror of master)
interface teclado_senha_if #(
    parameter int BITS = 6
);
    logic            bit_in;
    logic            bit_stb;
    logic            limpar;
    logic            resp_ok;
    logic            resp_erro;
    logic [BITS-1:0] senha_out;
    logic            senha_valida;
    logic            aberto;
    logic            bloqueado;
    logic [2:0]      tentativas;
    logic [2:0]      nbits;

    modport master (
        output bit_in, bit_stb, limpar, resp_ok, resp_erro,
        input  senha_out, senha_valida, aberto, bloqueado, tentativas, nbits
    );

    modport slave (
        input  bit_in, bit_stb, limpar, resp_ok, resp_erro,
        output senha_out, senha_valida, aberto, bloqueado, tentativas, nbits
    );
endinterface

// File: rtl/teclado_senha.sv
// teclado_senha: entry-side front end of the serial-check lock.
// Collects a BITS-wide code LSB first, presents it with a one-cycle valid
// strobe, waits for the lock's verdict and applies a timed lockout after
// MAX_TENTATIVAS consecutive failures.
//   clock    : system clock, rising edge
//   reset_n  : synchronous reset, active-high
//   bus      : teclado_senha_if.slave (button inputs, verdict inputs, status outputs)
//
// state    | meaning
// COLETA   | collecting code bits from the buttons
// ENVIA    | one cycle: senha_out complete, senha_valida high
// ESPERA   | waiting for green/red verdict or timeout
// LIBERADO | unlocked, held until limpar
// BLOQUEIO | lockout after too many failures
module teclado_senha #(
    parameter int BITS            = 6,
    parameter int MAX_TENTATIVAS  = 3,
    parameter int BLOQUEIO_CICLOS = 16,
    parameter int TIMEOUT_CICLOS  = 32
) (
    input  logic           clock,
    input  logic           reset_n,
    teclado_senha_if.slave bus
);
    localparam logic [2:0] COLETA   = 3'd0;
    localparam logic [2:0] ENVIA    = 3'd1;
    localparam logic [2:0] ESPERA   = 3'd2;
    localparam logic [2:0] LIBERADO = 3'd3;
    localparam logic [2:0] BLOQUEIO = 3'd4;

    // Limits of 1 would give a zero-width counter, so keep at least one bit.
    localparam int TW = (TIMEOUT_CICLOS  > 1) ? $clog2(TIMEOUT_CICLOS)  : 1;
    localparam int BW = (BLOQUEIO_CICLOS > 1) ? $clog2(BLOQUEIO_CICLOS) : 1;

    localparam logic [TW-1:0] TMO_FIM = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [BW-1:0] BLQ_FIM = BW'(BLOQUEIO_CICLOS - 1);
    localparam logic [2:0]    MAX_T   = 3'(MAX_TENTATIVAS);
    localparam logic [2:0]    NB_FIM  = 3'(BITS - 1);

    logic [2:0]      r_state;
    logic [BITS-1:0] r_senha;
    logic [2:0]      r_nbits;
    logic [2:0]      r_tent;
    logic [TW-1:0]   r_tmo;
    logic [BW-1:0]   r_blq;
    logic [2:0]      w_tent_prox;

    assign w_tent_prox = r_tent + 3'd1;

    always_ff @(posedge clock) begin
        if (reset_n) begin
            r_state <= COLETA;
            r_senha <= '0;
            r_nbits <= '0;
            r_tent  <= '0;
            r_tmo   <= '0;
            r_blq   <= '0;
        end else begin
            case (r_state)
                COLETA: begin
                    if (bus.limpar) begin
                        r_senha <= '0;
                        r_nbits <= '0;
                    end else if (bus.bit_stb) begin
                        r_senha[r_nbits] <= bus.bit_in;
                        if (r_nbits == NB_FIM) begin
                            r_nbits <= '0;
                            r_state <= ENVIA;
                        end else begin
                            r_nbits <= r_nbits + 3'd1;
                        end
                    end
                end
                ENVIA: begin
                    r_tmo   <= '0;
                    r_state <= ESPERA;
                end
                ESPERA: begin
                    // erro has priority over ok when both LEDs are lit
                    if (bus.resp_erro || (r_tmo == TMO_FIM)) begin
                        r_tent <= w_tent_prox;
                        if (w_tent_prox == MAX_T) begin
                            r_blq   <= '0;
                            r_state <= BLOQUEIO;
                        end else begin
                            r_senha <= '0;
                            r_state <= COLETA;
                        end
                    end else if (bus.resp_ok) begin
                        r_tent  <= '0;
                        r_state <= LIBERADO;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                LIBERADO: begin
                    if (bus.limpar) begin
                        r_senha <= '0;
                        r_state <= COLETA;
                    end
                end
                BLOQUEIO: begin
                    if (r_blq == BLQ_FIM) begin
                        r_tent  <= '0;
                        r_state <= COLETA;
                    end else begin
                        r_blq <= r_blq + BW'(1);
                    end
                end
                default: r_state <= COLETA;
            endcase
        end
    end

    assign bus.senha_out    = r_senha;
    assign bus.nbits        = r_nbits;
    assign bus.tentativas   = r_tent;
    assign bus.senha_valida = (r_state == ENVIA);
    assign bus.aberto       = (r_state == LIBERADO);
    assign bus.bloqueado    = (r_state == BLOQUEIO);
endmodule

// File: doc/teclado_senha.md
Name: teclado_senha

Overview:
- Entry-side front end for the serial-check lock.
- Collects a BITS-wide code one bit at a time from a button interface, LSB first.
- Presents the assembled code on senha_out with a valid strobe, then waits for the lock's green/red verdict.
- Enforces a failed-attempt limit with a timed lockout.

Parameters:
BITS, 6, code width in bits; also the width of senha_out
MAX_TENTATIVAS, 3, consecutive failures that trigger lockout (range 1..7)
BLOQUEIO_CICLOS, 16, lockout duration in clock cycles (minimum 1)
TIMEOUT_CICLOS, 32, cycles to wait for a verdict before counting a failure

Ports:
clock  input  1  system clock; all logic on the rising edge
reset_n  input  1  synchronous reset, active-high (1 = reset); single clock domain
bit_in  input  1  code bit value, sampled when bit_stb=1
bit_stb  input  1  one-cycle strobe: accept bit_in
limpar  input  1  clear the partial entry; also exits LIBERADO
resp_ok  input  1  lock green LED (ledverde)
resp_erro  input  1  lock red LED (ledvermelho)
senha_out  output  BITS  assembled code driven to the lock's senhaDigitada
senha_valida  output  1  one-cycle pulse: senha_out is complete
aberto  output  1  unlocked indication
bloqueado  output  1  lockout active
tentativas  output  3  consecutive failure count
nbits  output  3  bits collected so far in the current entry

Behaviour:
- Reset (reset_n=1 at an edge) wins over all other inputs, including mid-entry, mid-wait and mid-lockout:
  - state=COLETA
  - senha_out=0, senha_valida=0, aberto=0, bloqueado=0, tentativas=0, nbits=0
  - lockout and timeout counters = 0
- COLETA:
  - On bit_stb=1: senha_out[nbits] <= bit_in; nbits <= nbits+1.
  - When the strobe delivers bit BITS-1: go to ENVIA next cycle; nbits <= 0.
  - limpar=1 in the same cycle as bit_stb: limpar wins, the bit is dropped, senha_out=0, nbits=0.
  - resp_ok and resp_erro are ignored in this state.
- ENVIA (exactly 1 cycle):
  - senha_valida=1; timeout counter <= 0; then go to ESPERA.
  - Latency: senha_valida rises on the cycle after the edge that captured the last bit.
- ESPERA:
  - senha_out is held stable; bit_stb and limpar are ignored; timeout counter increments each cycle.
  - resp_erro=1, or timeout counter reaches TIMEOUT_CICLOS-1: failure. tentativas <= tentativas+1.
    - If the new count equals MAX_TENTATIVAS: go to BLOQUEIO, lockout counter <= 0.
    - Otherwise: go to COLETA, senha_out <= 0.
  - resp_ok=1 with resp_erro=0: go to LIBERADO; tentativas <= 0.
  - resp_ok and resp_erro both 1 in the same cycle: treated as failure (erro wins).
- LIBERADO:
  - aberto=1; bit_stb is ignored.
  - limpar=1: go to COLETA, aberto <= 0, senha_out <= 0.
- BLOQUEIO:
  - bloqueado=1; bit_stb, limpar, resp_ok and resp_erro are all ignored.
  - Lockout counter increments each cycle. When it reaches BLOQUEIO_CICLOS-1: go to COLETA, tentativas <= 0, bloqueado <= 0.
  - Total lockout = BLOQUEIO_CICLOS cycles.
- Output timing: all outputs are registered, or decoded from the state register only; no combinational path from inputs to outputs.
- Counter widths: size the counters with $clog2 of their limit; they never wrap in legal operation.

Test Plan:
- Reset, then strobe bits 0,0,1,1,0,1 on six consecutive cycles -> senha_out=6'b101100; senha_valida high for exactly 1 cycle, on the cycle after the 6th strobe.
- Continuing from that entry, drive resp_ok=1 three cycles after senha_valida -> aberto=1, tentativas=0. Then limpar=1 -> aberto=0, nbits=0, senha_out=0.
- Enter any code and answer resp_erro three times in a row -> tentativas steps 1, 2, 3; bloqueado=1 for exactly 16 cycles; strobes issued during lockout leave nbits=0. Afterwards tentativas=0.
- Enter a code and send no response -> failure after 32 cycles in ESPERA; tentativas=1; state returns to COLETA.
- Strobe 3 bits, then drive limpar and bit_stb together -> nbits=0, senha_out=0. Then assert reset_n during ESPERA with resp_ok=1 in the same cycle -> all outputs at reset values; aberto stays 0.
- Drive resp_ok=1 and resp_erro=1 in the same cycle -> tentativas increments; aberto stays 0.
